// File: rtl/mp8i_parity_gen_if.sv
// rtl/mp8i_parity_gen_if.sv - MB/MA datapath and IOT bus bundle for the parity generator/checker
interface mp8i_parity_gen_if #(
    parameter int CNT_W = 4
);
    logic             enable;
    logic [11:0]      mb;
    logic [11:0]      ma;
    logic             wr_strobe;
    logic             rd_strobe;
    logic             mem_par_in;
    logic             iot_smp;
    logic             iot_cmp;
    logic             par_out;
    logic             par_valid;
    logic             chk_done;
    logic             par_err;
    logic [11:0]      err_addr;
    logic [CNT_W-1:0] err_cnt;
    logic             int_rq;
    logic             skip;

    // Drives the memory/IOT side: strobes, data words and IOT pulses.
    modport master (
        output enable, mb, ma, wr_strobe, rd_strobe, mem_par_in, iot_smp, iot_cmp,
        input  par_out, par_valid, chk_done, par_err, err_addr, err_cnt, int_rq, skip
    );

    modport slave (
        input  enable, mb, ma, wr_strobe, rd_strobe, mem_par_in, iot_smp, iot_cmp,
        output par_out, par_valid, chk_done, par_err, err_addr, err_cnt, int_rq, skip
    );
endinterface

// File: rtl/mp8i_parity_gen.sv
// rtl/mp8i_parity_gen.sv - memory parity generator on writes, checker with sticky error/IRQ on reads
module mp8i_parity_gen #(
    parameter bit ODD   = 1'b1,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mp8i_parity_gen_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WGEN = 2'd1,
        S_RCHK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             par_out_q, par_out_d;
    logic             par_valid_q, par_valid_d;
    logic             chk_done_q, chk_done_d;
    logic             par_err_q, par_err_d;
    logic [11:0]      err_addr_q, err_addr_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             skip_q, skip_d;
    logic [11:0]      hold_mb_q, hold_mb_d;
    logic [11:0]      hold_ma_q, hold_ma_d;
    logic             hold_par_q, hold_par_d;
    logic             mismatch;

    function automatic logic parity_of(input logic [11:0] w);
        return (^w) ^ ODD;
    endfunction

    // Only a read being checked this cycle with checking enabled can flag.
    assign mismatch = (state_q == S_RCHK) && bus.enable
                      && (parity_of(hold_mb_q) != hold_par_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            par_out_q   <= 1'b0;
            par_valid_q <= 1'b0;
            chk_done_q  <= 1'b0;
            par_err_q   <= 1'b0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
            skip_q      <= 1'b0;
            hold_mb_q   <= '0;
            hold_ma_q   <= '0;
            hold_par_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            chk_done_q  <= chk_done_d;
            par_err_q   <= par_err_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
            skip_q      <= skip_d;
            hold_mb_q   <= hold_mb_d;
            hold_ma_q   <= hold_ma_d;
            hold_par_q  <= hold_par_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        chk_done_d  = 1'b0;
        hold_mb_d   = hold_mb_q;
        hold_ma_d   = hold_ma_q;
        hold_par_d  = hold_par_q;

        case (state_q)
            S_IDLE: begin
                if (bus.wr_strobe) begin
                    par_out_d   = parity_of(bus.mb);
                    par_valid_d = 1'b1;
                    state_d     = S_WGEN;
                end else if (bus.rd_strobe) begin
                    hold_mb_d  = bus.mb;
                    hold_ma_d  = bus.ma;
                    hold_par_d = bus.mem_par_in;
                    state_d    = S_RCHK;
                end
            end
            S_WGEN: begin
                state_d = S_IDLE;
            end
            S_RCHK: begin
                chk_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Error bookkeeping: a new error overrides a coincident clear, and the
    // address is recorded only when the flag is (re)armed by this error.
    always_comb begin
        par_err_d  = par_err_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;

        if (bus.iot_cmp) begin
            par_err_d = 1'b0;
        end

        if (mismatch) begin
            if (!par_err_q || bus.iot_cmp) begin
                err_addr_d = hold_ma_q;
            end
            par_err_d = 1'b1;
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        skip_d = bus.iot_smp && !par_err_q;
    end

    assign bus.par_out   = par_out_q;
    assign bus.par_valid = par_valid_q;
    assign bus.chk_done  = chk_done_q;
    assign bus.par_err   = par_err_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.int_rq    = par_err_q & bus.enable;
    assign bus.skip      = skip_q;

endmodule

// File: tb/tb_mp8i_parity_gen.sv
// tb/tb_mp8i_parity_gen.sv - self-checking bench for mp8i_parity_gen
module tb_mp8i_parity_gen;
    localparam bit ODD   = 1'b1;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    mp8i_parity_gen_if #(.CNT_W(CNT_W)) bus ();

    mp8i_parity_gen #(.ODD(ODD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks;
    int n_fail;

    bit          exp_err;
    logic [11:0] exp_addr;
    int          exp_cnt;
    bit          exp_pout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Parity bit that makes the 13-bit total odd (ODD=1) or even (ODD=0).
    function automatic bit ref_par(input logic [11:0] w);
        return (($countones(w) % 2) == 1) ^ ODD;
    endfunction

    task automatic model_reset();
        exp_err  = 0;
        exp_addr = '0;
        exp_cnt  = 0;
        exp_pout = 0;
    endtask

    task automatic check_flags(input string tag);
        n_checks++;
        if (bus.par_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s par_err: got %b want %b", tag, bus.par_err, exp_err);
        end
        n_checks++;
        if (bus.err_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL %s err_addr: got %o want %o", tag, bus.err_addr, exp_addr);
        end
        n_checks++;
        if (int'(bus.err_cnt) !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d want %0d", tag, bus.err_cnt, exp_cnt);
        end
        n_checks++;
        if (bus.int_rq !== (exp_err & bus.enable)) begin
            n_fail++;
            $display("FAIL %s int_rq: got %b want %b", tag, bus.int_rq, exp_err & bus.enable);
        end
    endtask

    task automatic do_write(input logic [11:0] w, input bit also_rd);
        @(negedge clk);
        bus.mb        = w;
        bus.wr_strobe = 1'b1;
        bus.rd_strobe = also_rd;
        bus.mem_par_in = ~ref_par(w);
        @(negedge clk);
        bus.wr_strobe = 1'b0;
        bus.rd_strobe = 1'b0;
        exp_pout = ref_par(w);
        n_checks++;
        if (bus.par_valid !== 1'b1 || bus.par_out !== exp_pout) begin
            n_fail++;
            $display("FAIL write_pulse mb=%o: valid=%b par_out=%b want valid=1 par_out=%b",
                     w, bus.par_valid, bus.par_out, exp_pout);
        end
        @(negedge clk);
        n_checks++;
        if (bus.par_valid !== 1'b0 || bus.par_out !== exp_pout || bus.chk_done !== 1'b0) begin
            n_fail++;
            $display("FAIL write_after mb=%o: valid=%b par_out=%b chk_done=%b want 0 %b 0",
                     w, bus.par_valid, bus.par_out, bus.chk_done, exp_pout);
        end
    endtask

    task automatic do_read(input logic [11:0] w, input bit p, input logic [11:0] a,
                           input bit cmp);
        bit mism;
        @(negedge clk);
        bus.mb         = w;
        bus.mem_par_in = p;
        bus.ma         = a;
        bus.rd_strobe  = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0;
        bus.mb        = $urandom;
        bus.ma        = $urandom;
        bus.iot_cmp   = cmp;
        n_checks++;
        if (bus.chk_done !== 1'b0) begin
            n_fail++;
            $display("FAIL read_early ma=%o: chk_done=%b want 0", a, bus.chk_done);
        end
        @(negedge clk);
        bus.iot_cmp = 1'b0;
        mism = bus.enable && (ref_par(w) != p);
        if (cmp) exp_err = 0;
        if (mism) begin
            if (!exp_err) exp_addr = a;
            exp_err = 1;
            if (exp_cnt < CNT_MAX) exp_cnt++;
        end
        n_checks++;
        if (bus.chk_done !== 1'b1) begin
            n_fail++;
            $display("FAIL read_done ma=%o: chk_done=%b want 1", a, bus.chk_done);
        end
        check_flags("read");
    endtask

    task automatic do_smp();
        bit want;
        @(negedge clk);
        want = !exp_err;
        bus.iot_smp = 1'b1;
        @(negedge clk);
        bus.iot_smp = 1'b0;
        n_checks++;
        if (bus.skip !== want) begin
            n_fail++;
            $display("FAIL smp_skip: got %b want %b", bus.skip, want);
        end
        @(negedge clk);
        n_checks++;
        if (bus.skip !== 1'b0) begin
            n_fail++;
            $display("FAIL smp_skip_end: got %b want 0", bus.skip);
        end
    endtask

    task automatic do_cmp();
        @(negedge clk);
        bus.iot_cmp = 1'b1;
        @(negedge clk);
        bus.iot_cmp = 1'b0;
        exp_err = 0;
        check_flags("cmp");
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({bus.par_out, bus.par_valid, bus.chk_done, bus.par_err, bus.err_addr,
             bus.err_cnt, bus.int_rq, bus.skip} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs: po=%b pv=%b cd=%b pe=%b ea=%o ec=%0d irq=%b sk=%b want all 0",
                     tag, bus.par_out, bus.par_valid, bus.chk_done, bus.par_err,
                     bus.err_addr, bus.err_cnt, bus.int_rq, bus.skip);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.mb = '0; bus.ma = '0;
        bus.wr_strobe = 0; bus.rd_strobe = 0; bus.mem_par_in = 0;
        bus.iot_smp = 0; bus.iot_cmp = 0;
        model_reset();
        #13;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        do_write(12'o0000, 0);
        do_write(12'o0001, 0);
        do_write(12'o7777, 0);
        do_write(12'o5252, 0);
    endtask

    task automatic test_read();
        do_read(12'o0003, 1'b1, 12'o0200, 0);
        do_read(12'o0003, 1'b0, 12'o0200, 0);
        do_read(12'o0017, 1'b0, 12'o0400, 0);
        for (int i = 0; i < 16; i++) do_read(12'o0000, 1'b0, 12'(i), 0);
    endtask

    task automatic test_iot();
        do_smp();
        do_cmp();
        do_smp();
        do_read(12'o0000, 1'b0, 12'o0123, 0);
        do_read(12'o0000, 1'b0, 12'o0321, 1);
        do_cmp();
    endtask

    task automatic test_strobes_and_enable();
        do_write(12'o1234, 1);
        @(negedge clk);
        n_checks++;
        if (bus.chk_done !== 1'b0) begin
            n_fail++;
            $display("FAIL coincident_rd: chk_done=%b want 0", bus.chk_done);
        end
        @(negedge clk);
        bus.mb = 12'o0000; bus.wr_strobe = 1'b1;
        @(negedge clk);
        bus.wr_strobe = 1'b0;
        bus.mb = 12'o0000; bus.mem_par_in = 1'b0; bus.rd_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bus.chk_done !== 1'b0 || bus.par_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wgen_strobe: chk_done=%b par_valid=%b want 0 0",
                         bus.chk_done, bus.par_valid);
            end
        end
        check_flags("wgen_strobe");
        @(negedge clk);
        bus.enable = 1'b0;
        do_read(12'o0000, 1'b0, 12'o0777, 0);
        do_read(12'o0000, 1'b0, 12'o0555, 0);
        do_read(12'o0000, 1'b0, 12'o0666, 0);
        bus.enable = 1'b1;
        check_flags("reenable");
    endtask

    task automatic test_mid_reset();
        do_read(12'o0000, 1'b0, 12'o0010, 0);
        @(negedge clk);
        bus.mb = 12'o0000; bus.mem_par_in = 1'b0; bus.ma = 12'o0070; bus.rd_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bus.chk_done !== 1'b0 || bus.par_err !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset: chk_done=%b par_err=%b want 0 0",
                         bus.chk_done, bus.par_err);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            bus.enable = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 6))
                0, 1:    do_write(12'($urandom), 0);
                2, 3, 4: do_read(12'($urandom), 1'($urandom), 12'($urandom),
                                 ($urandom_range(0, 7) == 0));
                5:       do_smp();
                default: do_cmp();
            endcase
        end
        bus.enable = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write();
        test_read();
        test_iot();
        test_strobes_and_enable();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
